// File: rtl/acc_pkg.sv
// Shared definitions for the sum stream accumulator.
// Holds the frame state encoding, the width of one reconstructed adder beat,
// the default frame length / accumulator width, and a helper that rebuilds
// a beat from the adder's sum byte and carry-out.
package acc_pkg;

  // Frame progress: no beat yet, partway through a frame, result presented.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StAccum = 2'd1,
    StHold  = 2'd2
  } acc_state_e;

  // One adder result is 8 sum bits plus the carry-out.
  localparam int unsigned BeatW = 9;

  localparam int unsigned DefaultBeats = 4;
  localparam int unsigned DefaultAccW  = 16;

  // Carry-out becomes the MSB so the beat is the true 9-bit adder result.
  function automatic logic [BeatW-1:0] beat_value(input logic cout, input logic [7:0] s);
    return {cout, s};
  endfunction

endpackage

// File: rtl/sum_stream_accumulator.sv
// Sum stream accumulator.
// Accepts adder results (8-bit sum + carry-out) over a valid/ready input,
// accumulates BEATS of them into an ACC_W-bit wrapping total and presents one
// result per frame over a valid/ready output, with a sticky overflow flag.
//
// Ports:
//   clk_i        rising-edge clock
//   rst_ni       asynchronous active-low reset
//   clear_i      synchronous frame abort, beats any handshake in the same cycle
//   in_valid_i   upstream beat valid
//   in_ready_o   block can take a beat (IDLE/ACCUM, and not in reset)
//   in_s_i       sum byte from the adder
//   in_cout_i    carry-out from the adder
//   out_valid_o  frame result valid (HOLD)
//   out_ready_i  downstream accepts the result
//   out_data_o   accumulated frame total
//   out_ovf_o    total wrapped at least once during the frame
module sum_stream_accumulator
  import acc_pkg::*;
#(
  parameter int unsigned BEATS = DefaultBeats,
  parameter int unsigned ACC_W = DefaultAccW
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       in_s_i,
  input  logic             in_cout_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [ACC_W-1:0] out_data_o,
  output logic             out_ovf_o
);

  localparam int unsigned CntW = $clog2(BEATS + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(BEATS - 1);

  acc_state_e      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  // Holds in_ready low while reset is asserted and until the first edge after release.
  logic             rdy_q;

  logic [ACC_W-1:0] beat_ext;
  logic [ACC_W:0]   sum;
  logic             in_fire;
  logic             out_fire;

  assign beat_ext = {{(ACC_W - BeatW){1'b0}}, beat_value(in_cout_i, in_s_i)};

  // Single ACC_W+1-bit adder; the top bit is the wrap carry.
  assign sum = {1'b0, acc_q} + {1'b0, beat_ext};

  // Outputs decode registered state only.
  assign in_ready_o  = rdy_q && (state_q != StHold);
  assign out_valid_o = (state_q == StHold);
  assign out_data_o  = acc_q;
  assign out_ovf_o   = ovf_q;

  assign in_fire  = in_valid_i && in_ready_o;
  assign out_fire = out_valid_o && out_ready_i;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    if (clear_i) begin
      state_d = StIdle;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle, StAccum: begin
          if (in_fire) begin
            acc_d = sum[ACC_W-1:0];
            ovf_d = ovf_q | sum[ACC_W];
            cnt_d = cnt_q + CntW'(1);
            // With BEATS == 1 the very first beat completes the frame.
            state_d = (cnt_q == LastCnt) ? StHold : StAccum;
          end
        end
        StHold: begin
          if (out_fire) begin
            state_d = StIdle;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sum_stream_accumulator.sv
// Directed bench for sum_stream_accumulator: a default-width instance and an
// ACC_W = 10 instance share one stimulus stream so wrap behaviour can be
// compared against the wide case.
module tb_sum_stream_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clear;
  logic        in_valid;
  logic [7:0]  in_s;
  logic        in_cout;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic        out_ovf;

  logic        in_ready10;
  logic        out_valid10;
  logic [9:0]  out_data10;
  logic        out_ovf10;

  int n_tests;
  int n_fail;

  sum_stream_accumulator dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .in_s_i      (in_s),
    .in_cout_i   (in_cout),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_data),
    .out_ovf_o   (out_ovf)
  );

  sum_stream_accumulator #(
    .BEATS (4),
    .ACC_W (10)
  ) dut10 (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clear_i     (clear),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready10),
    .in_s_i      (in_s),
    .in_cout_i   (in_cout),
    .out_valid_o (out_valid10),
    .out_ready_i (out_ready),
    .out_data_o  (out_data10),
    .out_ovf_o   (out_ovf10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one input cycle, then sample 1 time unit after the edge.
  task automatic beat(input logic v, input logic [7:0] s, input logic c);
    in_valid = v;
    in_s     = s;
    in_cout  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_s      = 8'h00;
    in_cout   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    #3;
    check("rst_in_ready", 32'(in_ready), 32'h0);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_data", 32'(out_data), 32'h0);
    check("rst_out_ovf", 32'(out_ovf), 32'h0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'h1);

    // Back-to-back frame, out_ready high
    beat(1'b1, 8'h10, 1'b0);
    beat(1'b1, 8'h20, 1'b0);
    beat(1'b1, 8'hFF, 1'b1);
    check("t1_valid_before_last", 32'(out_valid), 32'h0);
    beat(1'b1, 8'h01, 1'b0);
    in_valid = 1'b0;
    check("t1_valid", 32'(out_valid), 32'h1);
    check("t1_data", 32'(out_data), 32'h230);
    check("t1_ovf", 32'(out_ovf), 32'h0);
    check("t1_in_ready_hold", 32'(in_ready), 32'h0);
    check("t1_data10", 32'(out_data10), 32'h230);
    idle_cycle();
    check("t1_back_idle_valid", 32'(out_valid), 32'h0);
    check("t1_back_idle_ready", 32'(in_ready), 32'h1);

    // Output stall with in_valid kept high
    out_ready = 1'b0;
    beat(1'b1, 8'h10, 1'b0);
    beat(1'b1, 8'h20, 1'b0);
    beat(1'b1, 8'hFF, 1'b1);
    beat(1'b1, 8'h01, 1'b0);
    for (int i = 0; i < 5; i++) begin
      beat(1'b1, 8'h55, 1'b0);
      check("t2_stall_data", 32'(out_data), 32'h230);
      check("t2_stall_ready", 32'(in_ready), 32'h0);
      check("t2_stall_valid", 32'(out_valid), 32'h1);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    idle_cycle();
    check("t2_released", 32'(out_valid), 32'h0);
    for (int i = 0; i < 4; i++) beat(1'b1, 8'h01, 1'b0);
    in_valid = 1'b0;
    check("t2_next_frame", 32'(out_data), 32'h4);
    check("t2_next_valid", 32'(out_valid), 32'h1);
    idle_cycle();

    // Overflow on the narrow instance
    for (int i = 0; i < 4; i++) beat(1'b1, 8'hFF, 1'b1);
    in_valid = 1'b0;
    check("t3_data10", 32'(out_data10), 32'h3FC);
    check("t3_ovf10", 32'(out_ovf10), 32'h1);
    check("t3_data16", 32'(out_data), 32'h7FC);
    check("t3_ovf16", 32'(out_ovf), 32'h0);
    idle_cycle();
    for (int i = 0; i < 4; i++) beat(1'b1, 8'h00, 1'b0);
    in_valid = 1'b0;
    check("t3_zero_valid10", 32'(out_valid10), 32'h1);
    check("t3_zero_data10", 32'(out_data10), 32'h0);
    check("t3_zero_ovf10", 32'(out_ovf10), 32'h0);
    idle_cycle();

    // Gapped input: valid 1,0,0,1,0,1,1 with beats 1,x,x,2,x,3,4
    beat(1'b1, 8'h01, 1'b0);
    beat(1'b0, 8'hAA, 1'b1);
    beat(1'b0, 8'hBB, 1'b1);
    beat(1'b1, 8'h02, 1'b0);
    beat(1'b0, 8'hCC, 1'b1);
    beat(1'b1, 8'h03, 1'b0);
    check("t4_valid_before_last", 32'(out_valid), 32'h0);
    beat(1'b1, 8'h04, 1'b0);
    in_valid = 1'b0;
    check("t4_valid", 32'(out_valid), 32'h1);
    check("t4_data", 32'(out_data), 32'hA);
    idle_cycle();

    // Clear coincident with a third beat
    beat(1'b1, 8'h50, 1'b0);
    beat(1'b1, 8'h50, 1'b0);
    clear = 1'b1;
    beat(1'b1, 8'h50, 1'b0);
    clear = 1'b0;
    check("t5_clear_data", 32'(out_data), 32'h0);
    check("t5_clear_ready", 32'(in_ready), 32'h1);
    for (int i = 0; i < 3; i++) beat(1'b1, 8'h01, 1'b0);
    check("t5_valid_before_last", 32'(out_valid), 32'h0);
    beat(1'b1, 8'h01, 1'b0);
    in_valid = 1'b0;
    check("t5_valid", 32'(out_valid), 32'h1);
    check("t5_data", 32'(out_data), 32'h4);
    idle_cycle();

    // Asynchronous reset while holding a result
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(1'b1, 8'h10, 1'b0);
    in_valid = 1'b0;
    check("t6_hold_data", 32'(out_data), 32'h40);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(out_valid), 32'h0);
    check("t6_rst_data", 32'(out_data), 32'h0);
    check("t6_rst_ready", 32'(in_ready), 32'h0);
    #4 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    beat(1'b1, 8'h11, 1'b0);
    beat(1'b1, 8'h22, 1'b0);
    beat(1'b1, 8'h33, 1'b0);
    beat(1'b1, 8'h44, 1'b0);
    in_valid = 1'b0;
    check("t6_fresh_valid", 32'(out_valid), 32'h1);
    check("t6_fresh_data", 32'(out_data), 32'hAA);
    check("t6_fresh_ovf", 32'(out_ovf), 32'h0);
    idle_cycle();
    check("t6_done_valid", 32'(out_valid), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sum_stream_accumulator.md
# sum_stream_accumulator

Downstream consumer of the 8-bit adder stage. Accepts a stream of adder results (8-bit sum plus carry-out) over a valid/ready handshake, reconstructs each 9-bit value, and accumulates a fixed number of beats into a wide running total. Emits one accumulated result per frame over a second valid/ready handshake, with a per-frame overflow flag.

## Interface
Parameters:
- BEATS, 4: accepted input beats per frame; must be ≥ 1.
- ACC_W, 16: accumulator and result width; must be ≥ 9.

Ports:
- clock  in  1  single clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; reset is asserted when low.
- clear  in  1  synchronous frame abort.
- in_valid  in  1  the upstream beat is valid.
- in_ready  out  1  the block can accept a beat.
- in_s  in  8  sum byte from the adder.
- in_cout  in  1  carry-out from the adder.
- out_valid  out  1  the frame result is valid.
- out_ready  in  1  the downstream consumer accepts the result.
- out_data  out  ACC_W  accumulated frame total.
- out_ovf  out  1  the total wrapped at least once during this frame.

## Operation
- States:
  - IDLE: no beat accepted in the current frame.
  - ACCUM: 1 to BEATS-1 beats accepted.
  - HOLD: result presented.
- Beat value is {in_cout, in_s}, 9 bits, zero-extended to ACC_W.
- Input accept: fires when in_valid && in_ready. in_ready = 1 in IDLE and ACCUM, 0 in HOLD. No input bypass while in HOLD.
- On each accept:
  - acc ← (acc + beat) mod 2^ACC_W.
  - ovf ← ovf | carry out of bit ACC_W-1.
  - beat count increments.
- Transitions on accept:
  - IDLE → ACCUM.
  - IDLE → HOLD directly when BEATS = 1.
  - ACCUM → HOLD on the BEATS-th accept.
- In HOLD:
  - out_valid = 1.
  - out_data = acc and out_ovf = ovf, held stable until the output handshake.
- Output handshake fires when out_valid && out_ready. It moves the block to IDLE and clears acc, ovf and the count.
- clear:
  - Forces IDLE and clears acc, ovf and the count in any state, including dropping a pending result in HOLD.
  - clear takes precedence over a simultaneous input or output handshake; the beat is not counted.
- Beat counter width is clog2(BEATS+1). No wrap is possible because the counter resets at frame end.
- Reset: state IDLE, acc = 0, ovf = 0, count = 0, out_valid = 0, out_ovf = 0, out_data = 0. in_ready = 0 while reset is low, and 1 from the first cycle after release.

## Timing
- out_valid rises on the cycle after the BEATS-th input accept edge. That edge registers the final sum, so latency from the last beat to the result is 1 cycle.
- The earliest next input accept is the cycle after the output handshake. Minimum frame period is BEATS + 1 cycles, plus any out_ready stall.
- in_ready and out_valid are registered-state decodes. There is no combinational path from in_valid or out_ready to any output.
- Gaps in in_valid are allowed; only accepted beats count.
- Asserting reset mid-frame or in HOLD clears all outputs asynchronously, with no clock edge required.

## Structure
- Shared package acc_pkg holds:
  - the state typedef (IDLE, ACCUM, HOLD);
  - the beat width constant (9);
  - the default BEATS and ACC_W values.
- Single flat module. The datapath is one ACC_W+1-bit adder; the top bit is the overflow carry. No sub-module.

## Test plan
- Default params, beats (s, cout) = (0x10,0), (0x20,0), (0xFF,1), (0x01,0) back-to-back with out_ready = 1 → out_valid high exactly 1 cycle after the 4th accept, out_data = 0x0230, out_ovf = 0, then back to IDLE.
- Same frame with out_ready held 0 for 5 cycles while in_valid = 1 → out_data stable at 0x0230, in_ready = 0, no extra beats counted. The next frame starts after the handshake.
- ACC_W = 10, four beats of (0xFF,1), i.e. 0x1FF each → out_data = 0x3FC, out_ovf = 1. The next frame of four zeros → out_data = 0, out_ovf = 0.
- Default params, in_valid toggling 1,0,0,1,0,1,1 carrying beats 1,x,x,2,x,3,4 → out_data = 0x000A, and the result appears 1 cycle after the 7th cycle.
- After 2 beats of 0x50, pulse clear coincident with a third valid beat of 0x50 → that beat is dropped. The following 4 beats of 0x01 → out_data = 0x0004.
- Drive reset low while in HOLD → out_valid and out_data go to 0 without a clock edge. After release, a fresh 4-beat frame sums correctly.
